sd_cmd_responder: RTL

Card-side endpoint of the SD CMD line. It deserializes 48-bit host command frames, validates framing, and presents index and argument to card-model logic. It then serializes the 48-bit or 136-bit response that logic supplies. It is used as an SD card emulator behind the host controller, for simulation and loopback on the board. It runs entirely in the SD clock domain driven by the host.

---
 rtl/sd_cmd_responder_pkg.sv | 41 ++++
 rtl/sd_crc7.sv | 23 ++
 rtl/sd_cmd_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_responder_pkg.sv
// Shared state encoding, frame geometry and CRC7 helper for the SD CMD-line responder.
// Receive-side CRC checking is enabled by defining SD_RESP_CRC_CHECK_EN.
package sd_cmd_responder_pkg;

    localparam int unsigned SHORT_LEN = 48;
    localparam int unsigned LONG_LEN  = 136;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned ARG_W     = 32;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned PAYLOAD_W = 128;
    localparam int unsigned BIT_CNT_W = 8;
    localparam int unsigned NCR_W     = 7;
    localparam int unsigned RX_SR_W   = SHORT_LEN - 2;

    // Bit positions inside a 48-bit frame; the start bit is bit 47.
    localparam int unsigned POS_START = 47;
    localparam int unsigned POS_TRANS = 46;
    localparam int unsigned POS_IDX   = 40;
    localparam int unsigned POS_ARG   = 8;
    localparam int unsigned POS_CRC   = 1;
    localparam int unsigned POS_END   = 0;

    localparam logic [IDX_W-1:0] R2_HEADER = 6'b111111;
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_DELIVER,
        ST_WAIT_RESP,
        ST_TX
    } state_t;

    // One serial CRC7 step (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr restarts from zero and may absorb a bit in the same cycle.
module sd_crc7
    import sd_cmd_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= en ? crc7_step('0, din) : '0;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line endpoint: receives 48-bit commands, returns R1/R2 responses.
// Define SD_RESP_CRC_CHECK_EN to build the receive-side CRC7 checker.
module sd_cmd_responder
    import sd_cmd_responder_pkg::*;
#(
    parameter int unsigned RESP_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_in,
    output logic                 cmd_out,
    output logic                 cmd_oe,
    output logic                 cmd_valid,
    output logic [IDX_W-1:0]     cmd_index,
    output logic [ARG_W-1:0]     cmd_arg,
    output logic                 crc_err,
    input  logic                 resp_valid,
    output logic                 resp_ready,
    input  logic                 resp_long,
    input  logic [IDX_W-1:0]     resp_index,
    input  logic [ARG_W-1:0]     resp_arg,
    input  logic [PAYLOAD_W-1:0] resp_payload
);

    state_t               state, state_nxt;
    logic [RX_SR_W-1:0]   rx_sr, rx_sr_nxt;
    logic [BIT_CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [NCR_W-1:0]     ncr_cnt, ncr_cnt_nxt;
    logic [LONG_LEN-1:0]  tx_sr, tx_sr_nxt;
    logic [BIT_CNT_W-1:0] tx_left, tx_left_nxt;
    logic                 tx_long, tx_long_nxt;

    logic                 cmd_out_nxt, cmd_oe_nxt, cmd_valid_nxt, crc_err_nxt, resp_ready_nxt;
    logic [IDX_W-1:0]     cmd_index_nxt;
    logic [ARG_W-1:0]     cmd_arg_nxt;

    logic [SHORT_LEN-1:0] rx_frame;
    logic [LONG_LEN-1:0]  resp_frame;
    logic                 frame_bad, rx_crc_bad, report_drop, ncr_met;
    logic                 rx_crc_clr, rx_crc_en;
    logic                 tx_crc_clr, tx_crc_en, tx_crc_din;
    logic [CRC_W-1:0]     tx_crc;

    logic                 tx_go, long_src;
    logic [LONG_LEN-1:0]  sr_src;
    logic [BIT_CNT_W-1:0] left_src, drv_pos;
    logic                 unused_bits;

    // Complete frame as seen at the end-bit edge: implied start bit, shifted bits, live end bit.
    assign rx_frame  = {1'b0, rx_sr, cmd_in};
    assign frame_bad = !rx_frame[POS_TRANS] || !rx_frame[POS_END] || rx_crc_bad;
    assign ncr_met   = (ncr_cnt >= NCR_W'(RESP_DELAY));

    // Response frames are left-aligned so both lengths shift out of bit LONG_LEN-1.
    assign resp_frame = resp_long
        ? {2'b00, R2_HEADER, resp_payload[PAYLOAD_W-1:1], 1'b1}
        : {2'b00, resp_index, resp_arg, {CRC_W{1'b0}}, 1'b1, {(LONG_LEN-SHORT_LEN){1'b0}}};

`ifdef SD_RESP_CRC_CHECK_EN
    logic [CRC_W-1:0] rx_crc;

    sd_crc7 u_rx_crc (
        .clk (clk),
        .rst (rst),
        .clr (rx_crc_clr),
        .en  (rx_crc_en),
        .din (cmd_in),
        .crc (rx_crc)
    );

    assign rx_crc_bad  = (rx_crc != rx_frame[POS_CRC +: CRC_W]);
    assign report_drop = 1'b1;
`else
    assign rx_crc_bad  = 1'b0;
    assign report_drop = 1'b0;
`endif

    sd_crc7 u_tx_crc (
        .clk (clk),
        .rst (rst),
        .clr (tx_crc_clr),
        .en  (tx_crc_en),
        .din (tx_crc_din),
        .crc (tx_crc)
    );

    assign unused_bits = ^{rx_frame[POS_START], rx_frame[POS_CRC +: CRC_W], resp_payload[0],
                           rx_crc_clr, rx_crc_en};

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        rx_sr_nxt      = rx_sr;
        rx_cnt_nxt     = rx_cnt;
        ncr_cnt_nxt    = ncr_cnt;
        tx_sr_nxt      = tx_sr;
        tx_left_nxt    = tx_left;
        tx_long_nxt    = tx_long;
        cmd_out_nxt    = cmd_out;
        cmd_oe_nxt     = cmd_oe;
        cmd_valid_nxt  = 1'b0;
        crc_err_nxt    = 1'b0;
        cmd_index_nxt  = cmd_index;
        cmd_arg_nxt    = cmd_arg;
        resp_ready_nxt = resp_ready;
        rx_crc_clr     = 1'b0;
        rx_crc_en      = 1'b0;
        tx_crc_clr     = 1'b0;
        tx_crc_en      = 1'b0;
        tx_crc_din     = 1'b0;
        tx_go          = 1'b0;
        sr_src         = tx_sr;
        left_src       = tx_left;
        long_src       = tx_long;
        drv_pos        = '0;

        if (!ncr_met) begin
            ncr_cnt_nxt = ncr_cnt + NCR_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (!cmd_in) begin
                    state_nxt  = ST_RX;
                    rx_cnt_nxt = BIT_CNT_W'(SHORT_LEN - 1);
                    rx_crc_clr = 1'b1;
                end
            end
            ST_RX: begin
                rx_sr_nxt  = {rx_sr[RX_SR_W-2:0], cmd_in};
                rx_cnt_nxt = rx_cnt - BIT_CNT_W'(1);
                rx_crc_en  = (rx_cnt > BIT_CNT_W'(POS_ARG));
                if (rx_cnt == BIT_CNT_W'(1)) begin
                    state_nxt   = ST_DELIVER;
                    ncr_cnt_nxt = NCR_W'(1);
                    if (frame_bad) begin
                        crc_err_nxt = report_drop;
                    end else begin
                        cmd_valid_nxt = 1'b1;
                        cmd_index_nxt = rx_frame[POS_IDX +: IDX_W];
                        cmd_arg_nxt   = rx_frame[POS_ARG +: ARG_W];
                    end
                end
            end
            ST_DELIVER: begin
                if (cmd_valid && (cmd_index != '0)) begin
                    state_nxt      = ST_WAIT_RESP;
                    resp_ready_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                // A new host command takes priority over a pending response.
                if (!cmd_in) begin
                    state_nxt      = ST_RX;
                    rx_cnt_nxt     = BIT_CNT_W'(SHORT_LEN - 1);
                    rx_crc_clr     = 1'b1;
                    resp_ready_nxt = 1'b0;
                end else if (resp_valid && resp_ready) begin
                    state_nxt      = ST_TX;
                    resp_ready_nxt = 1'b0;
                    tx_crc_clr     = 1'b1;
                    tx_go          = 1'b1;
                    sr_src         = resp_frame;
                    long_src       = resp_long;
                    left_src       = resp_long ? BIT_CNT_W'(LONG_LEN) : BIT_CNT_W'(SHORT_LEN);
                end
            end
            ST_TX: begin
                tx_go = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Shared serializer; the first bit may go out on the handshake edge itself.
        if (tx_go) begin
            tx_sr_nxt   = sr_src;
            tx_left_nxt = left_src;
            tx_long_nxt = long_src;
            if (left_src == '0) begin
                cmd_oe_nxt  = 1'b0;
                cmd_out_nxt = 1'b1;
                state_nxt   = ST_IDLE;
            end else if (ncr_met) begin
                drv_pos     = left_src - BIT_CNT_W'(1);
                cmd_oe_nxt  = 1'b1;
                tx_crc_din  = sr_src[LONG_LEN-1];
                tx_crc_en   = !long_src && (drv_pos >= BIT_CNT_W'(POS_ARG));
                if (!long_src && (drv_pos >= BIT_CNT_W'(POS_CRC)) && (drv_pos < BIT_CNT_W'(POS_ARG))) begin
                    cmd_out_nxt = tx_crc[3'(drv_pos - BIT_CNT_W'(POS_CRC))];
                end else begin
                    cmd_out_nxt = sr_src[LONG_LEN-1];
                end
                tx_sr_nxt   = {sr_src[LONG_LEN-2:0], 1'b0};
                tx_left_nxt = drv_pos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rx_sr      <= '0;
            rx_cnt     <= '0;
            ncr_cnt    <= '0;
            tx_sr      <= '0;
            tx_left    <= '0;
            tx_long    <= 1'b0;
            cmd_out    <= 1'b1;
            cmd_oe     <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            crc_err    <= 1'b0;
            resp_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_sr      <= rx_sr_nxt;
            rx_cnt     <= rx_cnt_nxt;
            ncr_cnt    <= ncr_cnt_nxt;
            tx_sr      <= tx_sr_nxt;
            tx_left    <= tx_left_nxt;
            tx_long    <= tx_long_nxt;
            cmd_out    <= cmd_out_nxt;
            cmd_oe     <= cmd_oe_nxt;
            cmd_valid  <= cmd_valid_nxt;
            cmd_index  <= cmd_index_nxt;
            cmd_arg    <= cmd_arg_nxt;
            crc_err    <= crc_err_nxt;
            resp_ready <= resp_ready_nxt;
        end
    end

endmodule
